// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus payload types and arbiter FSM state encoding.
package common;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } cbus_arb_state_t;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [LEN_W-1:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic              ready;
        logic              last;
        logic [DATA_W-1:0] rdata;
    } cbus_resp_t;

    // Owner index width: at least one bit even for a single master.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cbus_rr_pick.sv
// Rotating priority encoder: first set valid bit scanning upward from ptr_i, wrapping.
module cbus_rr_pick
    import common::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    // Scan offsets from farthest to nearest so the nearest candidate wins last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int o = int'(N) - 1; o >= 0; o--) begin
            for (int j = 0; j < int'(N); j++) begin
                if ((IW'(j) == ptr_i) && valid_i[(j + o) % int'(N)]) begin
                    found_o = 1'b1;
                    idx_o   = IW'((j + o) % int'(N));
                end
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// N-to-1 CBus arbiter with burst-level grant lock.
// Fixed priority by default; define CBUS_ARBITER_ROUND_ROBIN_EN for round-robin.
module cbus_arbiter
    import common::*;
#(
    parameter  int unsigned NUM_INPUTS = 2,
    localparam int unsigned IDX_W      = idx_width(NUM_INPUTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] owner
);

    cbus_arb_state_t       state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [NUM_INPUTS-1:0] req_valid;
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      pick_ptr;
    logic                  burst_done;

`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = '0;
`endif

    // Collect upstream valid bits for the picker.
    always_comb begin
        req_valid = '0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            req_valid[i] = ireqs[i].valid;
        end
    end

    cbus_rr_pick #(
        .N (NUM_INPUTS)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Next state, owner/pointer update and the forwarding mux.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        oreq       = '0;
        busy       = 1'b0;
        burst_done = oresp.ready && oresp.last;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            iresps[i] = '0;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    owner_d = pick_idx;
                end
            end
            BUSY: begin
                busy = 1'b1;
                // Forward owner unconditionally, even if it drops valid mid-burst.
                for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                    if (IDX_W'(i) == owner_q) begin
                        oreq      = ireqs[i];
                        iresps[i] = oresp;
                    end
                end
                if (burst_done) begin
                    state_d = IDLE;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
                    ptr_d   = (owner_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : owner_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset silences the bus in the same cycle it is asserted.
        if (reset) begin
            oreq = '0;
            busy = 1'b0;
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                iresps[i] = '0;
            end
        end
    end

    // State and owner registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign owner = owner_q;

endmodule
